// File: rtl/tone_bank_ay.sv
// tone_bank_ay: bank of CHANNELS AY-style up-counting tone generators.
//   clk      : clock
//   reset    : synchronous, active-high reset
//   enable   : divided-clock tick; counters advance only when high
//   wr_en    : register write strobe
//   wr_chan  : target channel (writes to wr_chan >= CHANNELS are ignored)
//   wr_field : 0=period, 1=high_time, 2=control {restart, mode}, 3=ignored
//   wr_data  : write data
//   out      : per-channel tone output (registered state)
//   wrap     : per-channel one-cycle pulse when that channel's counter wraps
module tone_bank_ay #(
   parameter int CHANNELS    = 3,
   parameter int PERIOD_BITS = 12,
   parameter int CH_BITS     = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   wr_en,
   input  logic [CH_BITS-1:0]     wr_chan,
   input  logic [1:0]             wr_field,
   input  logic [PERIOD_BITS-1:0] wr_data,
   output logic [CHANNELS-1:0]    out,
   output logic [CHANNELS-1:0]    wrap
);
   localparam logic [PERIOD_BITS-1:0] one = PERIOD_BITS'(1);
   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [PERIOD_BITS-1:0] period, high_time, counter, counter_next;
      logic                   mode, state, wrap_q, sel, restart, hit;
      // counter never drops below 1, so period 0 wraps every tick just like period 1
      always_comb begin
         sel          = wr_en && wr_chan == CH_BITS'(c);
         restart      = sel && wr_field == 2'd2 && wr_data[1];
         hit          = counter >= period;
         counter_next = hit ? one : counter + one;
      end
      always_ff @(posedge clk) begin
         if (reset) begin
            period    <= '0;
            high_time <= '0;
            mode      <= 1'b0;
            counter   <= one;
            state     <= 1'b1;
            wrap_q    <= 1'b0;
         end else begin
            wrap_q <= 1'b0;
            if (sel && wr_field == 2'd0) period <= wr_data;
            if (sel && wr_field == 2'd1) high_time <= wr_data;
            if (sel && wr_field == 2'd2) mode <= wr_data[0];
            // restart beats a concurrent tick; the tick itself uses pre-edge registers
            if (restart) begin
               counter <= one;
               state   <= 1'b1;
            end else if (enable) begin
               counter <= counter_next;
               wrap_q  <= hit;
               state   <= mode ? (counter_next <= high_time) : (state ^ hit);
            end
         end
      end
      assign out[c]  = state;
      assign wrap[c] = wrap_q;
   end
endmodule

// File: tb/tb_tone_bank_ay.sv
// tb_tone_bank_ay: directed scoreboard bench for tone_bank_ay (3 channels, 12-bit periods).
module tb_tone_bank_ay;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        wr_en = 1'b0;
   logic [2:0]  wr_chan = '0;
   logic [1:0]  wr_field = '0;
   logic [11:0] wr_data = '0;
   logic [2:0]  out, wrap;

   typedef struct {
      string      tag;
      logic [2:0] mask;
      logic [2:0] o;
      logic [2:0] w;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   tone_bank_ay #(.CHANNELS(3), .PERIOD_BITS(12), .CH_BITS(3)) dut (
      .clk(clk), .reset(reset), .enable(enable), .wr_en(wr_en), .wr_chan(wr_chan),
      .wr_field(wr_field), .wr_data(wr_data), .out(out), .wrap(wrap)
   );

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic tick();
      enable = 1'b1;
      cyc();
      enable = 1'b0;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic wr(input int ch, input int f, input int d);
      wr_en = 1'b1;
      wr_chan = 3'(ch);
      wr_field = 2'(f);
      wr_data = 12'(d);
      cyc();
      wr_en = 1'b0;
   endtask

   task automatic push(input string tag, input logic [2:0] m, input logic [2:0] o, input logic [2:0] w);
      sb.push_back('{tag, m, o, w});
   endtask

   task automatic check();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         assert ({out & e.mask, wrap & e.mask} === {e.o & e.mask, e.w & e.mask})
         else begin
            errors++;
            $error("FAIL %s: out=%b wrap=%b expected out=%b wrap=%b (mask %b)",
                   e.tag, out, wrap, e.o, e.w, e.mask);
         end
      end
   endtask

   logic pat [10] = '{1, 0, 0, 0, 1, 1, 0, 0, 0, 1};

   initial begin
      cyc(3);
      reset = 1'b0;
      push("reset", 3'b111, 3'b111, 3'b000);
      check();

      // ch0 square, period 4, one tick every 8 clocks
      wr(0, 0, 4);
      for (int k = 1; k <= 12; k++) begin
         tick();
         push($sformatf("sq4 tick%0d", k), 3'b001, {2'b00, (k / 4) % 2 == 0}, {2'b00, k % 4 == 0});
         check();
         cyc();
         push($sformatf("sq4 idle%0d", k), 3'b001, {2'b00, (k / 4) % 2 == 0}, 3'b000);
         check();
         cyc(6);
      end

      // ch1 period 0 and period 1 both toggle every tick
      for (int p = 0; p <= 1; p++) begin
         wr(1, 0, p);
         wr(1, 2, 2);
         for (int k = 1; k <= 6; k++) begin
            tick();
            push($sformatf("p%0d tick%0d", p, k), 3'b010, {1'b0, k % 2 == 0, 1'b0}, 3'b010);
            check();
         end
      end

      // lowering period below the counter forces a wrap on the next tick
      wr(0, 0, 8);
      wr(0, 2, 2);
      ticks(3);
      push("pre-lower", 3'b001, 3'b001, 3'b000);
      check();
      wr(0, 0, 2);
      tick();
      push("lowered", 3'b001, 3'b000, 3'b001);
      check();

      // raising period at counter 4 to 12: nine more ticks to the wrap
      wr(0, 0, 8);
      wr(0, 2, 2);
      ticks(3);
      wr(0, 0, 12);
      for (int k = 1; k <= 9; k++) begin
         tick();
         push($sformatf("raised tick%0d", k), 3'b001, {2'b00, k != 9}, {2'b00, k == 9});
         check();
      end

      // ch2 pulse mode, period 5, high_time 2
      wr(2, 0, 5);
      wr(2, 1, 2);
      wr(2, 2, 3);
      for (int k = 1; k <= 10; k++) begin
         tick();
         push($sformatf("pulse tick%0d", k), 3'b100, {pat[k-1], 2'b00}, {k % 5 == 0, 2'b00});
         check();
      end
      wr(2, 1, 0);
      for (int k = 1; k <= 5; k++) begin
         tick();
         push($sformatf("ht0 tick%0d", k), 3'b100, 3'b000, {k == 5, 2'b00});
         check();
      end
      wr(2, 1, 7);
      for (int k = 1; k <= 5; k++) begin
         tick();
         push($sformatf("ht7 tick%0d", k), 3'b100, 3'b100, {k == 5, 2'b00});
         check();
      end

      // restart concurrent with enable: ch0 at counter 3/state 0, ch1 period 1
      wr(0, 0, 4);
      wr(0, 2, 2);
      wr(1, 0, 1);
      wr(1, 2, 2);
      ticks(6);
      push("pre-restart", 3'b011, 3'b010, 3'b010);
      check();
      wr_en = 1'b1;
      wr_chan = 3'd0;
      wr_field = 2'd2;
      wr_data = 12'd2;
      enable = 1'b1;
      cyc();
      wr_en = 1'b0;
      enable = 1'b0;
      push("restart+tick", 3'b011, 3'b001, 3'b010);
      check();
      for (int k = 1; k <= 4; k++) begin
         tick();
         push($sformatf("post-restart tick%0d", k), 3'b011, {1'b0, k % 2 == 1, k < 4}, {1'b0, 1'b1, k == 4});
         check();
      end

      // out-of-range channel and reserved field writes are ignored
      wr(5, 0, 7);
      wr(5, 1, 7);
      wr(5, 2, 3);
      wr(0, 3, 1);
      for (int k = 1; k <= 4; k++) begin
         tick();
         push($sformatf("ignored-wr tick%0d", k), 3'b011, {1'b0, k % 2 == 1, k == 4}, {1'b0, 1'b1, k == 4});
         check();
      end

      // reset mid-period with a concurrent write and tick
      wr(0, 0, 8);
      wr(0, 2, 2);
      ticks(13);
      push("pre-reset", 3'b001, 3'b000, 3'b000);
      check();
      reset = 1'b1;
      wr_en = 1'b1;
      wr_chan = 3'd0;
      wr_field = 2'd0;
      wr_data = 12'd3;
      enable = 1'b1;
      cyc();
      reset = 1'b0;
      wr_en = 1'b0;
      enable = 1'b0;
      push("mid-reset", 3'b111, 3'b111, 3'b000);
      check();
      tick();
      push("after-reset tick1", 3'b111, 3'b000, 3'b111);
      check();
      tick();
      push("after-reset tick2", 3'b111, 3'b111, 3'b111);
      check();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
